// File: rtl/circuit_sa1_fault_sim_pkg.sv
// rtl/circuit_sa1_fault_sim_pkg.sv - fault-site enumeration and helpers for the sa1 fault simulator
package circuit_sa1_fault_sim_pkg;

   localparam int NUM_SITES = 7;

   typedef enum logic [2:0] {
      SITE_A    = 3'd0,
      SITE_B    = 3'd1,
      SITE_C    = 3'd2,
      SITE_N1   = 3'd3,
      SITE_N2   = 3'd4,
      SITE_N3   = 3'd5,
      SITE_F    = 3'd6,
      SITE_NONE = 3'd7
   } site_e;

   // One-hot force mask for a site select; SITE_NONE yields an all-zero mask.
   function automatic logic [NUM_SITES-1:0] site_mask(input logic [2:0] sel);
      logic [NUM_SITES-1:0] m;
      for (int k = 0; k < NUM_SITES; k++) begin
         m[k] = (sel == 3'(k));
      end
      return m;
   endfunction

endpackage

// File: rtl/circuit_sa1_fault_sim_if.sv
// rtl/circuit_sa1_fault_sim_if.sv - stimulus and result bundle of the sa1 fault simulator
interface circuit_sa1_fault_sim_if;
   import circuit_sa1_fault_sim_pkg::*;

   logic                 A;
   logic                 B;
   logic                 C;
   logic [2:0]           fault_sel;
   logic                 cov_clr;
   logic                 F0;
   logic                 F1;
   logic                 detect;
   logic [NUM_SITES-1:0] coverage;

   modport master (
      output A, B, C, fault_sel, cov_clr,
      input  F0, F1, detect, coverage
   );

   modport slave (
      input  A, B, C, fault_sel, cov_clr,
      output F0, F1, detect, coverage
   );

endinterface

// File: rtl/circuit_sa1_fault_sim_netlist_eval.sv
// rtl/circuit_sa1_fault_sim_netlist_eval.sv - reference netlist with per-net force-to-one mask
module circuit_netlist_eval
   import circuit_sa1_fault_sim_pkg::*;
(
   input  logic                 A,
   input  logic                 B,
   input  logic                 C,
   input  logic [NUM_SITES-1:0] force_one,
   output logic                 F
);

   logic a, b, c, n1, n2, n3;

   // Forcing happens at each net's driver so every fanout branch sees the 1.
   assign a  = A | force_one[SITE_A];
   assign b  = B | force_one[SITE_B];
   assign c  = C | force_one[SITE_C];
   assign n1 = (a & b)   | force_one[SITE_N1];
   assign n2 = (~b)      | force_one[SITE_N2];
   assign n3 = (n2 & c)  | force_one[SITE_N3];
   assign F  = (n1 | n3) | force_one[SITE_F];

endmodule

// File: rtl/circuit_sa1_fault_sim.sv
// rtl/circuit_sa1_fault_sim.sv - good/faulty netlist pair with registered detect and sticky coverage
module circuit_sa1_fault_sim
   import circuit_sa1_fault_sim_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   circuit_sa1_fault_sim_if.slave   io
);

   logic [NUM_SITES-1:0] force_mask;
   logic                 good_f;
   logic                 bad_f;
   logic                 det_c;

   assign force_mask = site_mask(io.fault_sel);
   assign det_c      = good_f ^ bad_f;

   circuit_netlist_eval u_good (
      .A         (io.A),
      .B         (io.B),
      .C         (io.C),
      .force_one ('0),
      .F         (good_f)
   );

   circuit_netlist_eval u_bad (
      .A         (io.A),
      .B         (io.B),
      .C         (io.C),
      .force_one (force_mask),
      .F         (bad_f)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         io.F0       <= 1'b0;
         io.F1       <= 1'b0;
         io.detect   <= 1'b0;
         io.coverage <= '0;
      end else begin
         io.F0     <= good_f;
         io.F1     <= bad_f;
         io.detect <= det_c;
         // Clear beats a same-edge detection; force_mask is zero for SITE_NONE.
         if (io.cov_clr) begin
            io.coverage <= '0;
         end else if (det_c) begin
            io.coverage <= io.coverage | force_mask;
         end
      end
   end

endmodule

// File: tb/tb_circuit_sa1_fault_sim.sv
// tb/tb_circuit_sa1_fault_sim.sv - randomized self-checking bench for circuit_sa1_fault_sim
module tb_circuit_sa1_fault_sim;

   logic clk = 1'b0;
   logic rst = 1'b1;

   circuit_sa1_fault_sim_if io ();

   circuit_sa1_fault_sim dut (
      .clk (clk),
      .rst (rst),
      .io  (io.slave)
   );

   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   // Detecting vectors per site, bit index = {A,B,C}.
   logic [7:0] det_table [0:6];

   logic       exp_f0;
   logic       exp_f1;
   logic       exp_det;
   logic [6:0] exp_cov;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
      tests_run++;
      if (got !== want) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".F0"},  {7'd0, io.F0},     {7'd0, exp_f0});
      check({tag, ".F1"},  {7'd0, io.F1},     {7'd0, exp_f1});
      check({tag, ".det"}, {7'd0, io.detect}, {7'd0, exp_det});
      check({tag, ".cov"}, {1'b0, io.coverage}, {1'b0, exp_cov});
   endtask

   task automatic step(input logic [2:0] vec, input logic [2:0] sel, input logic clr, input string tag);
      logic good, det;
      io.A = vec[2];
      io.B = vec[1];
      io.C = vec[0];
      io.fault_sel = sel;
      io.cov_clr = clr;
      good = vec[1] ? vec[2] : vec[0];
      det  = (sel != 3'd7) && det_table[sel][vec];
      @(posedge clk);
      exp_f0  = good;
      exp_f1  = good ^ det;
      exp_det = det;
      if (clr)      exp_cov = '0;
      else if (det) exp_cov[sel] = 1'b1;
      #1;
      check_all(tag);
   endtask

   task automatic sweep(input logic [2:0] sel, input string tag);
      for (int v = 0; v < 8; v++) step(3'(v), sel, 1'b0, tag);
   endtask

   initial begin
      det_table[0] = 8'b0000_1100;
      det_table[1] = 8'b0001_0010;
      det_table[2] = 8'b0001_0001;
      det_table[3] = 8'b0001_1101;
      det_table[4] = 8'b0000_1000;
      det_table[5] = 8'b0001_1101;
      det_table[6] = 8'b0001_1101;

      io.A = 0; io.B = 0; io.C = 0; io.fault_sel = 3'd7; io.cov_clr = 0;
      exp_f0 = 0; exp_f1 = 0; exp_det = 0; exp_cov = '0;

      #12;
      check_all("reset");
      @(negedge clk);
      rst = 1'b0;

      sweep(3'd7, "nofault");
      check("nofault_cov", {1'b0, io.coverage}, 8'h00);

      sweep(3'd1, "b_sa1");
      check("b_sa1_cov", {1'b0, io.coverage}, 8'h02);

      step(3'd0, 3'd7, 1'b1, "clr");
      sweep(3'd4, "n2_sa1");
      check("n2_sa1_cov", {1'b0, io.coverage}, 8'h10);

      for (int s = 0; s < 7; s++) sweep(3'(s), "all_sites");
      check("all_cov", {1'b0, io.coverage}, 8'h7F);

      step(3'b010, 3'd0, 1'b1, "clr_wins");
      check("clr_wins_cov", {1'b0, io.coverage}, 8'h00);

      step(3'b000, 3'd0, 1'b0, "sel_hold");
      check("sel0_det", {7'd0, io.detect}, 8'h00);
      step(3'b000, 3'd3, 1'b0, "sel_chg");
      check("sel3_det", {7'd0, io.detect}, 8'h01);

      for (int i = 0; i < 300; i++) begin
         step(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              ($urandom_range(0, 19) == 0), "rand");
      end

      for (int s = 0; s < 7; s++) sweep(3'(s), "pre_rst");
      check("pre_rst_cov", {1'b0, io.coverage}, 8'h7F);
      step(3'b011, 3'd4, 1'b0, "mid_sweep");
      #2;
      rst = 1'b1;
      exp_f0 = 0; exp_f1 = 0; exp_det = 0; exp_cov = '0;
      #1;
      check_all("async_rst");
      #1;
      rst = 1'b0;
      sweep(3'd2, "post_rst");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/circuit_sa1_fault_sim.md
Name: circuit_sa1_fault_sim

Overview:
- Gate-level fault-simulation block for a 3-input combinational circuit.
- Evaluates the fault-free circuit (F0) and a copy with a single selectable stuck-at-1 fault (F1) side by side.
- Flags input vectors that expose the fault and accumulates per-site fault coverage.
- Used as the DUT in stuck-at fault detection experiments; the bench drives exhaustive {A,B,C} sweeps.

Parameters:
- NUM_SITES, 7, number of injectable fault sites (fixed by the netlist; not intended to be changed).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- A  input  1  primary input A.
- B  input  1  primary input B; mux select in the reference netlist.
- C  input  1  primary input C.
- fault_sel  input  3  fault site select: 0=A, 1=B, 2=C, 3=n1, 4=n2, 5=n3, 6=F, 7=no fault.
- cov_clr  input  1  synchronous clear of coverage mask.
- F0  output  1  registered fault-free output.
- F1  output  1  registered faulty-circuit output (selected net stuck at 1).
- detect  output  1  registered F0 XOR F1.
- coverage  output  7  sticky mask; bit k set once site k has been detected.

Behaviour:
- Reference netlist (shared by both copies):
  - n1 = A & B
  - n2 = ~B
  - n3 = n2 & C
  - F = n1 | n3
  - Equivalent function: F = B ? A : C.
- Faulty copy: the net selected by fault_sel is forced to 1 at its driver. All fanout of that net sees 1. A forced primary input affects only the faulty copy.
- fault_sel=7: faulty copy is identical to the fault-free copy, so F1==F0 and detect stays 0.
- Combinational evaluation of both copies from the current A, B, C and fault_sel. F0, F1 and detect are registered, giving 1-cycle latency from input sample to output.
- coverage[fault_sel] is set on the same edge that registers detect=1; it uses the combinational XOR, so the bit is visible together with detect.
  - Bits are never cleared except by rst or cov_clr.
  - fault_sel=7 never sets any bit.
- cov_clr=1 clears coverage on the next edge. If cov_clr and a detection occur on the same edge, the clear wins.
- Reset (asynchronous, any time including mid-sweep): F0=0, F1=0, detect=0, coverage=0. The first valid outputs appear on the first rising edge after rst deasserts.
- A change of fault_sel takes effect on the next edge. There is no pipeline flush and no stale-output suppression.
- Required detect vectors per site, written {A,B,C}:
  - site 0: 010, 011
  - site 1: 001, 100
  - site 2: 000, 100
  - sites 3, 5, 6: 000, 010, 011, 100
  - site 4: 011 only

Decomposition:
- Shared package: fault-site enumeration constants (SITE_A..SITE_F, SITE_NONE=7) and NUM_SITES.
- One natural sub-module: circuit_netlist_eval.
  - Combinational; inputs A, B, C and a 7-bit force-one mask; outputs F.
  - Instantiated twice: mask=0 for the good copy, one-hot from fault_sel for the faulty copy.
- The top holds the registers, XOR and coverage logic.

Test Plan:
- Reset: assert rst mid-sweep with coverage=7'h7F → all outputs 0 immediately, before any clock edge.
- Exhaustive sweep 000..111, fault_sel=7, one vector per cycle → F0 sequence 0,1,0,0,0,1,1,1 one cycle late; F1 identical; detect always 0; coverage stays 0.
- Sweep with fault_sel=1 (B sa1) → F1 = A for every vector; detect=1 only for 001 and 100; coverage=7'b0000010.
- Sweep with fault_sel=4 (n2 sa1) → detect=1 only for 011; coverage bit 4 set.
- Sequential sweeps of all sites 0..6 without clear → coverage=7'h7F. Then assert cov_clr together with a detecting vector → coverage=0 after the edge.
- Change fault_sel from 0 to 3 while holding 000 → detect goes 0→1 exactly one edge after the change.
